// File: rtl/classifier_metrics.sv
// classifier_metrics: argmax / loss / accuracy bookkeeping for the FC score stream.
// Accepts NUM_CLASSES signed Q8.8 scores per sample plus a one-hot label, then
// reports the predicted class, whether it matched, the per-sample loss, and
// maintains saturating running totals for the training loop.
module classifier_metrics #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int LOSS_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_CLASSES-1:0]         label,
    input  logic [DATA_WIDTH-1:0]          input_data,
    input  logic                           input_valid,
    input  logic                           clear_stats,
    output logic                           busy,
    output logic [$clog2(NUM_CLASSES)-1:0] pred_class,
    output logic                           pred_valid,
    output logic                           pred_correct,
    output logic [DATA_WIDTH-1:0]          sample_loss,
    output logic [LOSS_WIDTH-1:0]          loss_accum,
    output logic [COUNT_WIDTH-1:0]         correct_count,
    output logic [COUNT_WIDTH-1:0]         sample_count,
    output logic                           classify_done
);

    localparam int CLASS_W = $clog2(NUM_CLASSES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                        state_r;
    logic [NUM_CLASSES-1:0]        label_r;
    logic [CLASS_W-1:0]            idx_r;
    logic signed [DATA_WIDTH-1:0]  max_r;
    logic [DATA_WIDTH-1:0]         true_val_r;
    logic                          found_r;

    logic                          label_bit_s;
    logic                          pred_label_bit_s;
    logic                          last_idx_s;
    logic                          new_max_s;
    logic [DATA_WIDTH-1:0]         loss_s;
    logic [LOSS_WIDTH:0]           loss_sum_s;
    logic [LOSS_WIDTH-1:0]         loss_next_s;
    logic [COUNT_WIDTH-1:0]        sample_next_s;
    logic [COUNT_WIDTH-1:0]        correct_next_s;

    // Label lookups at the current score index and at the predicted class
    // (explicit mux avoids indexing past NUM_CLASSES with a CLASS_W-bit index).
    always_comb begin
        label_bit_s      = 1'b0;
        pred_label_bit_s = 1'b0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            label_bit_s      = label_bit_s      | (label_r[i] & (idx_r == CLASS_W'(i)));
            pred_label_bit_s = pred_label_bit_s | (label_r[i] & (pred_class == CLASS_W'(i)));
        end
    end

    // Score comparison, per-sample loss and saturating next values for the totals.
    always_comb begin
        last_idx_s = (idx_r == CLASS_W'(NUM_CLASSES - 1));
        new_max_s  = (idx_r == {CLASS_W{1'b0}}) || ($signed(input_data) > max_r);
        if (found_r) begin
            loss_s = {DATA_WIDTH{1'b1}} - true_val_r;
        end else begin
            loss_s = {DATA_WIDTH{1'b0}};
        end
        loss_sum_s = {1'b0, loss_accum} + {{(LOSS_WIDTH + 1 - DATA_WIDTH){1'b0}}, loss_s};
        if (loss_sum_s[LOSS_WIDTH]) begin
            loss_next_s = {LOSS_WIDTH{1'b1}};
        end else begin
            loss_next_s = loss_sum_s[LOSS_WIDTH-1:0];
        end
        if (sample_count == {COUNT_WIDTH{1'b1}}) begin
            sample_next_s = sample_count;
        end else begin
            sample_next_s = sample_count + COUNT_WIDTH'(1);
        end
        if (pred_label_bit_s && (correct_count != {COUNT_WIDTH{1'b1}})) begin
            correct_next_s = correct_count + COUNT_WIDTH'(1);
        end else begin
            correct_next_s = correct_count;
        end
    end

    // Classification FSM: collects scores, resolves the prediction, holds results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            label_r       <= {NUM_CLASSES{1'b0}};
            idx_r         <= {CLASS_W{1'b0}};
            max_r         <= {DATA_WIDTH{1'b0}};
            true_val_r    <= {DATA_WIDTH{1'b0}};
            found_r       <= 1'b0;
            busy          <= 1'b0;
            pred_class    <= {CLASS_W{1'b0}};
            pred_valid    <= 1'b0;
            pred_correct  <= 1'b0;
            sample_loss   <= {DATA_WIDTH{1'b0}};
            classify_done <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    classify_done <= 1'b0;
                    if (enable) begin
                        state_r    <= COLLECT;
                        busy       <= 1'b1;
                        label_r    <= label;
                        idx_r      <= {CLASS_W{1'b0}};
                        max_r      <= {1'b1, {(DATA_WIDTH - 1){1'b0}}};
                        true_val_r <= {DATA_WIDTH{1'b0}};
                        found_r    <= 1'b0;
                        pred_valid <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (!enable) begin
                        // Abort: nothing from this sample reaches the totals.
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else if (input_valid) begin
                        if (new_max_s) begin
                            max_r      <= $signed(input_data);
                            pred_class <= idx_r;
                        end
                        if (label_bit_s && !found_r) begin
                            true_val_r <= input_data;
                            found_r    <= 1'b1;
                        end
                        if (last_idx_s) begin
                            state_r <= RESOLVE;
                        end else begin
                            idx_r <= idx_r + CLASS_W'(1);
                        end
                    end
                end
                RESOLVE: begin
                    sample_loss  <= loss_s;
                    pred_correct <= pred_label_bit_s;
                    pred_valid   <= 1'b1;
                    busy         <= 1'b0;
                    state_r      <= DONE;
                end
                DONE: begin
                    if (!enable) begin
                        state_r       <= IDLE;
                        classify_done <= 1'b0;
                    end else begin
                        classify_done <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    busy          <= 1'b0;
                    classify_done <= 1'b0;
                end
            endcase
        end
    end

    // Running totals: clear_stats wins over the RESOLVE update on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loss_accum    <= {LOSS_WIDTH{1'b0}};
            correct_count <= {COUNT_WIDTH{1'b0}};
            sample_count  <= {COUNT_WIDTH{1'b0}};
        end else if (clear_stats) begin
            loss_accum    <= {LOSS_WIDTH{1'b0}};
            correct_count <= {COUNT_WIDTH{1'b0}};
            sample_count  <= {COUNT_WIDTH{1'b0}};
        end else if (state_r == RESOLVE) begin
            loss_accum    <= loss_next_s;
            correct_count <= correct_next_s;
            sample_count  <= sample_next_s;
        end
    end

endmodule
